// File: rtl/zorgian_coin_acceptor.sv
// Coin acceptor front end of the Zorgian vending datapath.
// Collects coins against a latched cost, offers the total to the change box
// or to the refund path, and keeps the saturating 2-bit coin stock counts.
module zorgian_coin_acceptor #(
    parameter int STOCK_MAX = 3,
    parameter int PAID_MAX  = 15
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic [3:0] Cost,
    input  logic       coin_valid,
    input  logic [2:0] coin_in,
    output logic       coin_ready,
    output logic       coin_reject,
    input  logic       cancel,
    output logic [3:0] Paid,
    output logic       paid_valid,
    input  logic       paid_ready,
    output logic       refund_valid,
    input  logic       refund_ready,
    input  logic       dispense_valid,
    input  logic [2:0] dispense_coin,
    output logic [1:0] Pentagons,
    output logic [1:0] Triangles,
    output logic [1:0] Circles,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam logic [2:0] CODE_CIRCLE   = 3'b001;
    localparam logic [2:0] CODE_TRIANGLE = 3'b011;
    localparam logic [2:0] CODE_PENTAGON = 3'b101;

    state_t     state;
    state_t     state_next;

    logic [3:0] paid_q;
    logic [3:0] cost_q;
    logic [3:0] pend_p;
    logic [3:0] pend_t;
    logic [3:0] pend_c;
    logic [1:0] stock_p;
    logic [1:0] stock_t;
    logic [1:0] stock_c;
    logic       reject_q;

    logic [2:0] coin_val;
    logic       coin_legal;
    logic [4:0] paid_sum;
    logic       handshake;
    logic       coin_accept;
    logic       coin_bad;
    logic       commit;
    logic       refund_done;
    logic       start_ok;

    // Stock after an optional commit of pending coins and an optional dispense.
    // The sum is formed 6 bits wide so the decrement happens before the clamp.
    function automatic logic [1:0] next_stock(input logic [1:0] cur,
                                              input logic [3:0] add,
                                              input logic       sub);
        logic [5:0] total;
        total = {4'b0000, cur} + {2'b00, add};
        if (sub && (total != 6'd0)) begin
            total = total - 6'd1;
        end
        if (total > 6'(STOCK_MAX)) begin
            return 2'(STOCK_MAX);
        end
        return total[1:0];
    endfunction

    assign coin_ready   = (state == COLLECT) && !cancel;
    assign coin_reject  = reject_q;
    assign Paid         = paid_q;
    assign paid_valid   = (state == DONE);
    assign refund_valid = (state == REFUND);
    assign busy         = (state != IDLE);
    assign Pentagons    = stock_p;
    assign Triangles    = stock_t;
    assign Circles      = stock_c;

    assign handshake   = coin_valid && coin_ready;
    assign paid_sum    = {1'b0, paid_q} + {2'b00, coin_val};
    assign coin_accept = handshake && coin_legal && (paid_sum <= 5'(PAID_MAX));
    assign coin_bad    = handshake && !coin_accept;
    assign commit      = (state == DONE) && paid_ready;
    assign refund_done = (state == REFUND) && refund_ready;
    assign start_ok    = (state == IDLE) && start && (Cost != 4'd0);

    // Decode the inserted coin into its face value.
    always_comb begin
        coin_val   = 3'd0;
        coin_legal = 1'b0;
        case (coin_in)
            CODE_CIRCLE: begin
                coin_val   = 3'd1;
                coin_legal = 1'b1;
            end
            CODE_TRIANGLE: begin
                coin_val   = 3'd3;
                coin_legal = 1'b1;
            end
            CODE_PENTAGON: begin
                coin_val   = 3'd5;
                coin_legal = 1'b1;
            end
            default: begin
                coin_val   = 3'd0;
                coin_legal = 1'b0;
            end
        endcase
    end

    // Transaction state register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cancel wins over any coin while collecting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_next = REFUND;
                end else if (coin_accept && (paid_sum >= {1'b0, cost_q})) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (paid_ready) begin
                    state_next = IDLE;
                end
            end
            REFUND: begin
                if (refund_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Running total, latched cost, pending coin counts and the reject pulse.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            paid_q   <= 4'd0;
            cost_q   <= 4'd0;
            pend_p   <= 4'd0;
            pend_t   <= 4'd0;
            pend_c   <= 4'd0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= coin_bad;
            if (start_ok) begin
                cost_q <= Cost;
                paid_q <= 4'd0;
                pend_p <= 4'd0;
                pend_t <= 4'd0;
                pend_c <= 4'd0;
            end else if (coin_accept) begin
                paid_q <= paid_sum[3:0];
                if (coin_in == CODE_PENTAGON) pend_p <= pend_p + 4'd1;
                if (coin_in == CODE_TRIANGLE) pend_t <= pend_t + 4'd1;
                if (coin_in == CODE_CIRCLE)   pend_c <= pend_c + 4'd1;
            end else if (commit || refund_done) begin
                paid_q <= 4'd0;
                pend_p <= 4'd0;
                pend_t <= 4'd0;
                pend_c <= 4'd0;
            end
        end
    end

    // Stock counts: credited with pending coins on commit, debited on dispense.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            stock_p <= 2'd0;
            stock_t <= 2'd0;
            stock_c <= 2'd0;
        end else begin
            stock_p <= next_stock(stock_p, commit ? pend_p : 4'd0,
                                  dispense_valid && (dispense_coin == CODE_PENTAGON));
            stock_t <= next_stock(stock_t, commit ? pend_t : 4'd0,
                                  dispense_valid && (dispense_coin == CODE_TRIANGLE));
            stock_c <= next_stock(stock_c, commit ? pend_c : 4'd0,
                                  dispense_valid && (dispense_coin == CODE_CIRCLE));
        end
    end

endmodule
